// File: rtl/div16_8_seq.sv
// Sequential unsigned restoring divider: 16-bit dividend / 8-bit divisor.
// Produces one quotient bit per clock and returns the result over a valid/ready handshake.
module div16_8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] q_reg, q_next;
  logic [7:0]  d_reg, d_next;
  logic [7:0]  r_reg, r_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] quotient_reg, quotient_next;
  logic [7:0]  remainder_reg, remainder_next;
  logic        dbz_reg, dbz_next;
  logic        out_valid_reg, out_valid_next;

  // The stored remainder is always below D, so its ninth bit is always zero and
  // is not kept; the trial value T carries the full 9 bits for the compare.
  logic [8:0]  t_calc;
  logic        t_ge_d;
  logic [7:0]  r_sub;
  logic [15:0] q_iter;
  logic [7:0]  r_iter;

  assign in_ready = (state_reg == IDLE) && !rst;

  assign t_calc = {r_reg, q_reg[15]};
  assign t_ge_d = (t_calc >= {1'b0, d_reg});
  // T < 2*D whenever T >= D, so T - D always fits in 8 bits.
  assign r_sub  = t_calc[7:0] - d_reg;
  assign q_iter = {q_reg[14:0], t_ge_d};
  assign r_iter = t_ge_d ? r_sub : t_calc[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      d_reg         <= d_next;
      r_reg         <= r_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    d_next         = d_reg;
    r_next         = r_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          q_next   = dividend;
          d_next   = divisor;
          r_next   = '0;
          cnt_next = '0;
          if (divisor == 8'd0) begin
            quotient_next  = 16'hFFFF;
            remainder_next = dividend[7:0];
            dbz_next       = 1'b1;
            out_valid_next = 1'b1;
            state_next     = DONE;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        q_next   = q_iter;
        r_next   = r_iter;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd15) begin
          quotient_next  = q_iter;
          remainder_next = r_iter;
          dbz_next       = 1'b0;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
      end
    endcase
  end

  assign out_valid   = out_valid_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div16_8_seq.sv
// Randomized self-checking bench for div16_8_seq against a plain-arithmetic
// division model (divide-by-zero returns all-ones quotient and dividend[7:0]).
module tb_div16_8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div16_8_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for result, hold under backpressure, handshake.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_dbz;
    int          exp_lat;
    int          lat;
    logic [31:0] recon;
    if (b == 8'd0) begin
      exp_q   = 16'hFFFF;
      exp_r   = a[7:0];
      exp_dbz = 1'b1;
      exp_lat = 0;
    end else begin
      exp_q   = a / 16'(b);
      exp_r   = 8'(a % 16'(b));
      exp_dbz = 1'b0;
      exp_lat = 16;
    end

    @(negedge clk);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);

    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("quotient", 32'(quotient), 32'(exp_q));
    check("remainder", 32'(remainder), 32'(exp_r));
    check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    if (b != 8'd0) begin
      recon = 32'(quotient) * 32'(b) + 32'(remainder);
      check("invariant", recon, 32'(a));
    end

    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_quotient", 32'(quotient), 32'(exp_q));
      check("hold_remainder", 32'(remainder), 32'(exp_r));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end

    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_return", 32'(in_ready), 32'd1);
    $display("[TB] op %04h / %02h -> q=%04h r=%02h dbz=%0b lat=%0d hold=%0d",
             a, b, quotient, remainder, div_by_zero, lat, hold);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] rd;
    int          seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases from the test plan.
    run_op(16'h2C88, 8'h39, 0);
    check("recover_200", 32'(quotient), 32'h00C8);
    run_op(16'hFFFF, 8'hFF, 0);
    run_op(16'h1234, 8'h10, 1);
    run_op(16'h0005, 8'h07, 0);
    run_op(16'h1234, 8'h00, 2);
    run_op(16'h0000, 8'h01, 0);
    run_op(16'hFFFF, 8'h01, 0);
    run_op(16'h1234, 8'h39, 5);

    // Reset at CALC iteration 8 discards the in-flight result.
    @(negedge clk);
    dividend = 16'h1234;
    divisor  = 8'h10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready_high", 32'(in_ready), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("midrst_no_result", 32'(seen_valid), 32'd0);
    run_op(16'h0100, 8'h02, 0);

    // Recover A from P = A*B.
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run_op(16'(ra) * 16'(rb), rb, int'($urandom_range(0, 2)));
      check("recover_a", 32'(quotient), 32'(ra));
      check("recover_rem", 32'(remainder), 32'd0);
    end

    // Arbitrary dividends, occasionally with a zero divisor.
    for (int i = 0; i < 60; i++) begin
      rd = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      run_op(rd, rb, int'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
